// File: rtl/reg64_rd_serializer_pkg.sv
// Shared types and defaults for the 64-bit register read-side serializer.
// No logic of its own; imported by the serializer top and its beat mux.
// Defines the two-state FSM encoding and the default widths.
package reg64_rd_serializer_pkg;

    // Default geometry: a 64-bit register streamed as four 16-bit beats.
    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_BEAT_W = 16;

    // IDLE: waiting for a read request. SEND: streaming snapshot beats.
    typedef enum logic {
        RDS_IDLE = 1'b0,
        RDS_SEND = 1'b1
    } rds_state_t;

    // Number of beats needed to carry one snapshot.
    function automatic int nbeats(input int data_w, input int beat_w);
        return data_w / beat_w;
    endfunction

    // Width of a beat index; at least one bit so a vector can be declared.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg64_rd_serializer_beat_mux.sv
// Selects one BEAT_W-wide slice of the snapshot by beat index.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; stability comes from the registered snapshot and index.
module reg64_rd_serializer_beat_mux
    import reg64_rd_serializer_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BEAT_W    = DEFAULT_BEAT_W,
    parameter int MSB_FIRST = 0,
    parameter int IDX_W     = idx_width(nbeats(DEFAULT_DATA_W, DEFAULT_BEAT_W))
) (
    input  logic [DATA_W-1:0] snap,
    input  logic [IDX_W-1:0]  idx,
    output logic [BEAT_W-1:0] data
);

    localparam int NBEATS = nbeats(DATA_W, BEAT_W);

    // Beat i is the i-th slice from the low end, or from the high end when MSB_FIRST.
    always_comb begin
        data = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (idx == IDX_W'(i)) begin
                if (MSB_FIRST != 0) begin
                    data = snap[(NBEATS-1-i)*BEAT_W +: BEAT_W];
                end else begin
                    data = snap[i*BEAT_W +: BEAT_W];
                end
            end
        end
    end

endmodule

// File: rtl/reg64_rd_serializer.sv
// Snapshots a register on request and streams it as BEAT_W beats over valid/ready.
// Latency: first beat valid one cycle after an accepted rd_req; rd_done one cycle after the last handshake.
// Backpressure: beat held stable while beat_valid && !beat_ready; rd_req outside the final handshake is dropped.
module reg64_rd_serializer
    import reg64_rd_serializer_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BEAT_W    = DEFAULT_BEAT_W,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              rd_abort,
    input  logic [DATA_W-1:0] rd_in,
    output logic              rd_busy,
    output logic [BEAT_W-1:0] beat_data,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic              beat_last,
    output logic              rd_done
);

    localparam int NBEATS = nbeats(DATA_W, BEAT_W);
    localparam int IDX_W  = idx_width(NBEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    // Geometry sanity: the snapshot must split into at least two whole beats.
    if ((DATA_W % BEAT_W) != 0) begin : g_bad_ratio
        $error("reg64_rd_serializer: DATA_W must be a multiple of BEAT_W");
    end
    if (NBEATS < 2) begin : g_bad_nbeats
        $error("reg64_rd_serializer: DATA_W/BEAT_W must be at least 2");
    end

    rds_state_t        state;
    rds_state_t        state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] snap;
    logic              capture;
    logic              done_nxt;
    logic              is_last;

    assign is_last = (idx == LAST_IDX);

    // FSM state, beat index and done pulse; reset returns everything to idle zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RDS_IDLE;
            idx     <= '0;
            rd_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            rd_done <= done_nxt;
        end
    end

    // Snapshot: plain enable register, loaded only when a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= '0;
        end else if (capture) begin
            snap <= rd_in;
        end
    end

    // Next-state logic: abort has priority over capture and over a same-cycle handshake.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            RDS_IDLE: begin
                if (!rd_abort && rd_req) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = RDS_SEND;
                end
            end
            RDS_SEND: begin
                if (rd_abort) begin
                    // Any beat handshaking now is consumed; nothing further is sent.
                    state_nxt = RDS_IDLE;
                    idx_nxt   = '0;
                end else if (beat_ready) begin
                    if (is_last) begin
                        done_nxt = 1'b1;
                        idx_nxt  = '0;
                        if (rd_req) begin
                            // Back-to-back: reload and keep streaming without a bubble.
                            capture = 1'b1;
                        end else begin
                            state_nxt = RDS_IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RDS_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign beat_valid = (state == RDS_SEND);
    assign rd_busy    = (state == RDS_SEND);
    assign beat_last  = (state == RDS_SEND) && is_last;

    reg64_rd_serializer_beat_mux #(
        .DATA_W    (DATA_W),
        .BEAT_W    (BEAT_W),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_beat_mux (
        .snap (snap),
        .idx  (idx),
        .data (beat_data)
    );

endmodule
